// File: rtl/counter_rd_pkg.sv
// Shared types and constants for the two-access 64-bit counter read master.
package counter_rd_pkg;

    localparam int CNT_W = 64;
    localparam int BUS_W = 32;
    localparam int TMO_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ_LO,
        WAIT_LO,
        REQ_HI,
        WAIT_HI,
        RESP
    } rd_state_t;

endpackage

// File: rtl/rd_timeout_timer.sv
// Acknowledge watchdog shared by both wait phases of the read sequence.
// "expired" is raised in the wait cycle where the count would reach LIMIT
// with no acknowledge, so at most LIMIT wait cycles are granted per request.
module rd_timeout_timer
    import counter_rd_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic hit,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(LIMIT - 1);

    logic [TMO_W-1:0] count;

    // Count wait cycles that pass without an acknowledge; restart before each wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !hit) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && !hit && (count == LAST);

endmodule

// File: rtl/atomic_count_reader.sv
// Read master that turns one 64-bit read command into an atomic low-word
// request followed by a plain high-word request, and reports the assembled
// value together with its modulo-2^64 delta from the last good read.
module atomic_count_reader
    import counter_rd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_valid_i,
    output logic             rd_ready_o,
    output logic             req_o,
    output logic             atomic_o,
    input  logic             ack_i,
    input  logic [BUS_W-1:0] count_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [CNT_W-1:0] res_data_o,
    output logic [CNT_W-1:0] res_delta_o,
    output logic             res_err_o
);

    rd_state_t        state;
    rd_state_t        state_next;
    logic [BUS_W-1:0] lo;
    logic [CNT_W-1:0] data_q;
    logic [CNT_W-1:0] delta_q;
    logic [CNT_W-1:0] last_q;
    logic [CNT_W-1:0] full_value;
    logic             err_q;
    logic             in_wait;
    logic             timer_clear;
    logic             expired;

    assign in_wait     = (state == WAIT_LO) || (state == WAIT_HI);
    assign timer_clear = (state == REQ_LO) || (state == REQ_HI);
    assign full_value  = {count_i, lo};

    rd_timeout_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (in_wait),
        .hit    (ack_i),
        .expired(expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; handshake and request outputs depend on state only.
    always_comb begin
        state_next  = state;
        rd_ready_o  = 1'b0;
        req_o       = 1'b0;
        atomic_o    = 1'b0;
        res_valid_o = 1'b0;
        case (state)
            IDLE: begin
                rd_ready_o = 1'b1;
                if (rd_valid_i) state_next = REQ_LO;
            end
            REQ_LO: begin
                req_o      = 1'b1;
                atomic_o   = 1'b1;
                state_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (ack_i)        state_next = REQ_HI;
                else if (expired) state_next = RESP;
            end
            REQ_HI: begin
                req_o      = 1'b1;
                state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (ack_i || expired) state_next = RESP;
            end
            RESP: begin
                res_valid_o = 1'b1;
                if (res_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Hold the snapshot low word until the high word arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo <= '0;
        end else if (state == WAIT_LO && ack_i) begin
            lo <= count_i;
        end
    end

    // Build the result registers when the sequence ends, either good or timed out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            delta_q <= '0;
            err_q   <= 1'b0;
        end else if (state == WAIT_HI && ack_i) begin
            data_q  <= full_value;
            delta_q <= full_value - last_q;
            err_q   <= 1'b0;
        end else if (in_wait && expired) begin
            data_q  <= '0;
            delta_q <= '0;
            err_q   <= 1'b1;
        end
    end

    // Remember the last good value once the consumer has taken the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= '0;
        end else if (state == RESP && res_ready_i && !err_q) begin
            last_q <= data_q;
        end
    end

    assign res_data_o  = data_q;
    assign res_delta_o = delta_q;
    assign res_err_o   = err_q;

endmodule

// File: tb/tb_atomic_count_reader.sv
// Randomised self-checking bench: models the 64-bit snapshot counter and the
// expected read results, latency and request pattern at transaction level.
module tb_atomic_count_reader;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_valid_i = 1'b0;
    logic        rd_ready_o;
    logic        req_o;
    logic        atomic_o;
    logic        ack_i = 1'b0;
    logic [31:0] count_i = '0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [63:0] res_data_o;
    logic [63:0] res_delta_o;
    logic        res_err_o;

    int          checkCount = 0;
    int          passCount = 0;
    logic [63:0] cnt = '0;
    logic [63:0] lastGood = '0;

    atomic_count_reader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_valid_i (rd_valid_i),
        .rd_ready_o (rd_ready_o),
        .req_o      (req_o),
        .atomic_o   (atomic_o),
        .ack_i      (ack_i),
        .count_i    (count_i),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .res_data_o (res_data_o),
        .res_delta_o(res_delta_o),
        .res_err_o  (res_err_o)
    );

    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_rd_ready"}, 64'(rd_ready_o), 64'd1);
        checkOutput({tag, "_req"}, 64'(req_o), 64'd0);
        checkOutput({tag, "_atomic"}, 64'(atomic_o), 64'd0);
        checkOutput({tag, "_res_valid"}, 64'(res_valid_o), 64'd0);
        checkOutput({tag, "_res_data"}, res_data_o, 64'd0);
        checkOutput({tag, "_res_delta"}, res_delta_o, 64'd0);
        checkOutput({tag, "_res_err"}, 64'(res_err_o), 64'd0);
    endtask

    // One full read: dlo/dhi are acknowledge delays in wait cycles (beyond TO
    // means no acknowledge in time), hold is result backpressure length.
    task automatic applyStimulus(input int dlo, input int dhi, input int hold,
                                 input bit trigBetween, input bit randTrig, input bit doReset);
        int          cyc = 1;
        int          countdown = 0;
        int          nreq = 0;
        int          phase = 0;
        bit          prevReq = 1'b0;
        bit          done = 1'b0;
        logic [31:0] word = '0;
        logic [31:0] snapHi = '0;
        logic [63:0] snapVal = '0;
        logic [63:0] expData;
        logic [63:0] expDelta;
        logic [63:0] heldData;
        logic [63:0] heldDelta;
        logic        heldErr;
        bit          expErr;
        int          expReq;
        int          expLat;

        expErr = (dlo > TO) || (dhi > TO);
        expReq = (dlo > TO) ? 1 : 2;
        expLat = (dlo > TO) ? TO + 2 : ((dhi > TO) ? 3 + dlo + TO : 3 + dlo + dhi);

        checkOutput("cmd_ready", 64'(rd_ready_o), 64'd1);
        rd_valid_i = 1'b1;
        @(posedge clk); #1;
        rd_valid_i = 1'b0;

        while (!done && cyc < 60) begin
            ack_i   = 1'b0;
            count_i = '0;
            if (req_o) begin
                checkOutput("req_spacing", 64'(prevReq), 64'd0);
                nreq++;
                if (atomic_o) begin
                    snapVal   = cnt;
                    word      = cnt[31:0];
                    snapHi    = cnt[63:32];
                    countdown = dlo;
                    phase     = 0;
                end else begin
                    word      = snapHi;
                    countdown = dhi;
                    phase     = 1;
                    if (trigBetween) cnt = cnt + 64'd1;
                end
            end else begin
                checkOutput("atomic_without_req", 64'(atomic_o), 64'd0);
                if (countdown > 0) begin
                    if (doReset && phase == 1) begin
                        reset = 1'b1;
                        #1;
                        checkIdleOutputs("async_reset");
                        @(posedge clk); #1;
                        reset    = 1'b0;
                        lastGood = '0;
                        ack_i    = 1'b1;
                        count_i  = $urandom;
                        @(posedge clk); #1;
                        ack_i    = 1'b0;
                        checkOutput("stray_ack_ready", 64'(rd_ready_o), 64'd1);
                        checkOutput("stray_ack_req", 64'(req_o), 64'd0);
                        return;
                    end
                    countdown--;
                    if (countdown == 0) begin
                        ack_i   = 1'b1;
                        count_i = word;
                    end
                end
            end
            prevReq = req_o;
            if (randTrig && $urandom_range(3) == 0) cnt = cnt + 64'd1;
            if (res_valid_o) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end

        checkOutput("result_seen", 64'(done), 64'd1);
        expData  = expErr ? 64'd0 : snapVal;
        expDelta = expErr ? 64'd0 : snapVal - lastGood;
        checkOutput("latency", 64'(cyc), 64'(expLat));
        checkOutput("req_count", 64'(nreq), 64'(expReq));
        checkOutput("res_err", 64'(res_err_o), 64'(expErr));
        checkOutput("res_data", res_data_o, expData);
        checkOutput("res_delta", res_delta_o, expDelta);

        heldData  = res_data_o;
        heldDelta = res_delta_o;
        heldErr   = res_err_o;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            ack_i = 1'b0;
            checkOutput("bp_valid", 64'(res_valid_o), 64'd1);
            checkOutput("bp_rd_ready", 64'(rd_ready_o), 64'd0);
            checkOutput("bp_req", 64'(req_o), 64'd0);
            checkOutput("bp_data", res_data_o, heldData);
            checkOutput("bp_delta", res_delta_o, heldDelta);
            checkOutput("bp_err", 64'(res_err_o), 64'(heldErr));
        end

        res_ready_i = 1'b1;
        @(posedge clk); #1;
        res_ready_i = 1'b0;
        ack_i       = 1'b0;
        checkOutput("post_hs_valid", 64'(res_valid_o), 64'd0);
        checkOutput("post_hs_ready", 64'(rd_ready_o), 64'd1);
        if (!expErr) lastGood = snapVal;
    endtask

    initial begin
        int dlo;
        int dhi;

        #12;
        checkIdleOutputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        checkIdleOutputs("after_reset");

        // Nominal read.
        cnt = 64'h0000_0001_FFFF_FFF0;
        applyStimulus(1, 1, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("nominal_last", lastGood, 64'h0000_0001_FFFF_FFF0);

        // Carry into the high word between the two accesses.
        cnt = 64'h0000_0002_FFFF_FFFF;
        applyStimulus(1, 1, 0, 1'b1, 1'b0, 1'b0);

        // Delta wraps around 2^64.
        cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        applyStimulus(1, 2, 0, 1'b0, 1'b0, 1'b0);
        cnt = 64'h0000_0000_0000_0001;
        applyStimulus(2, 1, 0, 1'b0, 1'b0, 1'b0);

        // Low-phase timeout with a late acknowledge, then a good read.
        cnt = 64'h0000_1234_0000_0010;
        applyStimulus(TO + 1, 1, 1, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout_last_kept", lastGood, 64'h1);
        applyStimulus(TO, TO, 0, 1'b0, 1'b0, 1'b0);

        // High-phase timeout.
        cnt = 64'h0000_0000_ABCD_0000;
        applyStimulus(1, TO + 1, 0, 1'b0, 1'b0, 1'b0);

        // Backpressure on the result.
        cnt = 64'h0000_0042_0000_0042;
        applyStimulus(1, 1, 10, 1'b0, 1'b1, 1'b0);

        // Reset while waiting for the high word, then a clean read.
        cnt = 64'h0000_0055_0000_0077;
        applyStimulus(1, 3, 0, 1'b0, 1'b0, 1'b1);
        cnt = 64'h0000_0099_8000_0000;
        applyStimulus(1, 1, 0, 1'b0, 1'b0, 1'b0);

        // Randomised reads.
        for (int i = 0; i < 30; i++) begin
            dlo = ($urandom_range(7) == 0) ? TO + 1 : $urandom_range(TO, 1);
            dhi = ($urandom_range(7) == 0) ? TO + 1 : $urandom_range(TO, 1);
            if ($urandom_range(3) == 0) cnt = {$urandom, $urandom};
            else cnt = cnt + 64'($urandom_range(1000));
            applyStimulus(dlo, dhi, $urandom_range(3), 1'($urandom_range(1)), 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
